mis_stimulus_gen: RTL and testbench
===================================

Name: mis_stimulus_gen

Overview:
- Stimulus and capture controller for multiple-input-switching (MIS) delay characterisation of a two-input NOR/inverter test chain.
- Drives the chain's two inputs with programmed edges separated by a signed skew (delta, in clock cycles).
- Samples the chain output through a synchroniser and reports cycles from the first input edge to the output settling.
- Sits between the measurement register bank and the chain instance; one measurement per start pulse.

Parameters:
- DELTA_W, 8, width of signed skew input (two's complement).
- CNT_W, 16, width of measurement counter/result.
- SETTLE_CYCLES, 16, cycles inputs are held at initial level before the first edge (>=1).
- MAX_WAIT, 1000, timeout in cycles counted from the first edge. Must be < 2^CNT_W and > 2^(DELTA_W-1)+2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; honoured only in IDLE
- delta  in  DELTA_W  signed skew: >0 A1 leads, <0 A2 leads, 0 simultaneous
- dir_rise  in  1  1: inputs go 0->1; 0: inputs go 1->0
- myout  in  1  chain output (asynchronous to clk)
- myinA1  out  1  chain input A1 (registered)
- myinA2  out  1  chain input A2 (registered)
- busy  out  1  high from the cycle after start acceptance until the DONE cycle
- done  out  1  one-cycle pulse on completion
- timeout  out  1  sticky until next accepted start; no output transition seen
- settle_err  out  1  sticky until next accepted start; output not at expected initial level after settle
- meas  out  CNT_W  result, held until next accepted start

Behaviour:
- Reset (rst=1 at a clk edge, including mid-operation):
  - State -> IDLE.
  - myinA1 = myinA2 = 0; busy, done, timeout, settle_err = 0; meas = 0; synchroniser flops cleared.
- myout passes through a 2-flop synchroniser (sync_out). All comparisons use sync_out.
- Expected levels (chain output = OR of inputs):
  - init_lvl = ~dir_rise; final_lvl = dir_rise.
  - Rise: output changes on the FIRST edge. Fall: output changes on the SECOND edge.
- On acceptance (IDLE and start=1), latch delta, dir_rise and |delta|. |delta| uses DELTA_W+1 bits so -2^(DELTA_W-1) is legal. Clear timeout, settle_err and meas.
- FSM:
  - IDLE: inputs hold their last driven value. start -> INIT.
  - INIT (SETTLE_CYCLES cycles): myinA1 = myinA2 = init_lvl. On the final cycle, check sync_out == init_lvl; on mismatch set settle_err and go to DONE with meas = 0. Otherwise go to EDGE1.
  - EDGE1 (1 cycle): drive the lead input to final_lvl. If delta=0, drive both. This cycle is t=0 and the counter starts at 0.
    - delta=0 -> WAIT_OUT.
    - otherwise -> GAP.
  - GAP: wait until t=|delta|, then drive the lag input to final_lvl on that cycle -> WAIT_OUT.
  - WAIT_OUT: counter increments every cycle from EDGE1 onward, including during GAP.
    - First cycle sync_out == final_lvl: meas = count, -> DONE.
    - count reaches MAX_WAIT first: timeout=1, meas = MAX_WAIT, -> DONE.
  - Detection is also active during GAP. If the output settles before the lag edge (rise case), capture meas there but still issue the lag edge, then -> DONE.
  - DONE (1 cycle): done=1, busy=0 -> IDLE. Inputs remain at final_lvl.
- start while busy: ignored (no queueing).
- A change of delta or dir_rise during busy has no effect (latched values are used).
- meas includes the 2-cycle synchroniser latency. Software subtracts 2.
- Counter never wraps (guaranteed by the MAX_WAIT constraint).

Decomposition:
- Shared package mis_pkg: FSM state enum (IDLE, INIT, EDGE1, GAP, WAIT_OUT, DONE), SYNC_STAGES=2 constant, default parameter constants.
- One sub-module: mis_sync2 (2-flop synchroniser with synchronous reset).

Test Plan:
- Rise, delta=0, bench models chain as zero-delay OR:
  - A1 and A2 rise on the same cycle, after exactly SETTLE_CYCLES=16 cycles of 0.
  - meas=2, done one pulse, timeout=0.
- Rise, delta=+5: A1 rises at t=0, A2 at t=5; meas=2; both inputs end at 1.
- Fall, delta=+5: A1 falls at t=0, A2 at t=5; output falls after A2; meas=7.
- Fall, delta=-128 (DELTA_W=8): A2 falls at t=0, A1 at t=128; meas=130.
- myout stuck 0 with dir_rise=1, MAX_WAIT=1000: timeout=1, meas=1000, done pulses.
  - Repeat with myout stuck 1: settle_err=1, meas=0, no input edges driven.
- rst asserted during GAP:
  - Next cycle IDLE, inputs 0, busy=0.
  - A start pulse issued while busy is ignored.
  - A new start after reset completes normally with meas=2.

Source files
------------

// File: rtl/mis_pkg.sv
// mis_pkg
// Shared constants for the MIS stimulus/capture controller:
//   - FSM state encodings (plain 3-bit constants so older tools and
//     waveform decoders can use them unchanged)
//   - synchroniser depth
//   - default parameter values used by mis_stimulus_gen
package mis_pkg;

  localparam int SYNC_STAGES = 2;

  localparam int DEF_DELTA_W       = 8;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_MAX_WAIT      = 1000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_INIT     = 3'd1;
  localparam state_t ST_EDGE1    = 3'd2;
  localparam state_t ST_GAP      = 3'd3;
  localparam state_t ST_WAIT_OUT = 3'd4;
  localparam state_t ST_DONE     = 3'd5;

endpackage

// File: rtl/mis_sync2.sv
// mis_sync2
// Multi-flop synchroniser (SYNC_STAGES deep) for one asynchronous bit.
// Ports:
//   clk    - destination clock
//   rst    - synchronous, active-high reset; clears every stage
//   d      - asynchronous input
//   q      - synchronised output, SYNC_STAGES cycles of latency
module mis_sync2
  import mis_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/mis_stimulus_gen.sv
// mis_stimulus_gen
// Stimulus and capture controller for multiple-input-switching delay
// characterisation of a two-input NOR/inverter chain (output = A1 | A2).
// One measurement per accepted start: hold both inputs at the initial
// level, check the output settled, launch the lead edge, launch the lag
// edge |delta| cycles later, then count cycles until the synchronised
// output reaches its final level (or MAX_WAIT expires).
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - one-cycle request, honoured only in IDLE
//   delta        - signed skew; >0 A1 leads, <0 A2 leads, 0 simultaneous
//   dir_rise     - 1: inputs go 0->1, 0: inputs go 1->0
//   myout        - chain output, asynchronous to clk
//   myinA1/A2    - registered chain inputs
//   busy, done   - run in progress / one-cycle completion pulse
//   timeout      - sticky: no output transition within MAX_WAIT
//   settle_err   - sticky: output not at initial level after settling
//   meas         - cycles from first edge to settled output (incl. sync)
//   dbg_state    - current FSM state for observation
//
// Handshake: start is a request strobe with busy acting as not-ready.
// A start seen while the FSM is in IDLE is accepted on that clock edge;
// any start while busy or done is high is dropped, never queued.
module mis_stimulus_gen
  import mis_pkg::*;
#(
  parameter int DELTA_W       = DEF_DELTA_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int MAX_WAIT      = DEF_MAX_WAIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DELTA_W-1:0] delta,
  input  logic               dir_rise,
  input  logic               myout,
  output logic               myinA1,
  output logic               myinA2,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               settle_err,
  output logic [CNT_W-1:0]   meas,
  output state_t             dbg_state
);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   settle_q;
  logic               dir_q;
  logic               lead_a2_q;
  logic               captured_q;
  logic [DELTA_W:0]   abs_q;

  logic               sync_out;
  logic               init_lvl;
  logic               final_lvl;
  logic               hit;
  logic [CNT_W-1:0]   cnt_inc;
  logic               gap_last;
  logic               at_max;
  logic               settle_last;
  logic [DELTA_W:0]   delta_ext;
  logic [DELTA_W:0]   delta_abs;

  mis_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (myout),
    .q   (sync_out)
  );

  assign init_lvl    = ~dir_q;
  assign final_lvl   = dir_q;
  assign hit         = (sync_out == final_lvl);
  assign cnt_inc     = cnt_q + 1'b1;
  // The lag edge is registered, so it is launched on the edge that ends
  // cycle |delta|-1 and is visible at the pins during cycle t = |delta|.
  assign gap_last    = (cnt_inc == CNT_W'(abs_q));
  assign at_max      = (cnt_q == CNT_W'(MAX_WAIT));
  assign settle_last = (settle_q == CNT_W'(SETTLE_CYCLES - 1));

  // One extra bit so that the most negative skew has a representable
  // magnitude (e.g. -128 -> 128 for an 8-bit delta).
  assign delta_ext = {delta[DELTA_W-1], delta};
  assign delta_abs = delta[DELTA_W-1] ? (~delta_ext + 1'b1) : delta_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      settle_q   <= '0;
      dir_q      <= 1'b0;
      lead_a2_q  <= 1'b0;
      captured_q <= 1'b0;
      abs_q      <= '0;
      myinA1     <= 1'b0;
      myinA2     <= 1'b0;
      timeout    <= 1'b0;
      settle_err <= 1'b0;
      meas       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dir_q      <= dir_rise;
            lead_a2_q  <= delta[DELTA_W-1];
            abs_q      <= delta_abs;
            captured_q <= 1'b0;
            settle_q   <= '0;
            timeout    <= 1'b0;
            settle_err <= 1'b0;
            meas       <= '0;
            myinA1     <= ~dir_rise;
            myinA2     <= ~dir_rise;
            state_q    <= ST_INIT;
          end
        end

        ST_INIT: begin
          if (settle_last) begin
            if (sync_out != init_lvl) begin
              settle_err <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              cnt_q   <= '0;
              state_q <= ST_EDGE1;
              if (abs_q == '0) begin
                myinA1 <= final_lvl;
                myinA2 <= final_lvl;
              end else if (lead_a2_q) begin
                myinA2 <= final_lvl;
              end else begin
                myinA1 <= final_lvl;
              end
            end
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end

        ST_EDGE1: begin
          cnt_q <= cnt_inc;
          if (abs_q == '0) begin
            state_q <= ST_WAIT_OUT;
          end else if (gap_last) begin
            // |delta| == 1: the lag edge belongs to the very next cycle.
            if (lead_a2_q) myinA1 <= final_lvl;
            else           myinA2 <= final_lvl;
            state_q <= ST_WAIT_OUT;
          end else begin
            state_q <= ST_GAP;
          end
        end

        ST_GAP: begin
          cnt_q <= cnt_inc;
          // A rising output can settle before the lag edge; keep the first
          // hit but still finish the stimulus sequence.
          if (hit && !captured_q) begin
            meas       <= cnt_q;
            captured_q <= 1'b1;
          end
          if (gap_last) begin
            if (lead_a2_q) myinA1 <= final_lvl;
            else           myinA2 <= final_lvl;
            state_q <= ST_WAIT_OUT;
          end
        end

        ST_WAIT_OUT: begin
          cnt_q <= cnt_inc;
          if (captured_q) begin
            state_q <= ST_DONE;
          end else if (hit) begin
            meas    <= cnt_q;
            state_q <= ST_DONE;
          end else if (at_max) begin
            timeout <= 1'b1;
            meas    <= CNT_W'(MAX_WAIT);
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q == ST_INIT) || (state_q == ST_EDGE1) ||
                (state_q == ST_GAP)  || (state_q == ST_WAIT_OUT);
  assign done = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mis_stimulus_gen.sv
// tb_mis_stimulus_gen
// Self-checking bench for mis_stimulus_gen. The chain is modelled as a
// zero-delay OR of the two inputs, or forced stuck at 0 / 1. Expected
// results are pushed to a queue when a measurement is launched and
// compared when done is observed.
module tb_mis_stimulus_gen;
  import mis_pkg::*;

  localparam int DELTA_W  = 8;
  localparam int CNT_W    = 16;
  localparam int SETTLE   = 16;
  localparam int MAX_WAIT = 1000;
  localparam int LIMIT    = 1500;

  typedef struct packed {
    logic [31:0] meas;
    logic [31:0] tmo;
    logic [31:0] serr;
    logic [31:0] done_cyc;
    logic [31:0] t_a1;
    logic [31:0] t_a2;
    logic [31:0] end_lvl;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               start;
  logic [DELTA_W-1:0] delta;
  logic               dir_rise;
  logic               myout;
  logic               myinA1;
  logic               myinA2;
  logic               busy;
  logic               done;
  logic               timeout;
  logic               settle_err;
  logic [CNT_W-1:0]   meas;
  state_t             dbg_state;
  logic [1:0]         mode;   // 0: OR chain, 1: stuck 0, 2: stuck 1

  assign myout = (mode == 2'd0) ? (myinA1 | myinA2) : (mode == 2'd2);

  mis_stimulus_gen #(
    .DELTA_W       (DELTA_W),
    .CNT_W         (CNT_W),
    .SETTLE_CYCLES (SETTLE),
    .MAX_WAIT      (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .delta      (delta),
    .dir_rise   (dir_rise),
    .myout      (myout),
    .myinA1     (myinA1),
    .myinA2     (myinA2),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .settle_err (settle_err),
    .meas       (meas),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model of one measurement on an ideal chain.
  function automatic exp_t model(input int d, input logic dir, input logic [1:0] m);
    exp_t e;
    int   ad;
    logic init_l;
    logic stuck_l;
    ad      = (d < 0) ? -d : d;
    init_l  = ~dir;
    stuck_l = (m == 2'd2);
    e       = '0;
    if (m != 2'd0 && stuck_l != init_l) begin
      e.serr     = 1;
      e.meas     = 0;
      e.done_cyc = SETTLE + 1;
      e.t_a1     = 0;
      e.t_a2     = 0;
      e.end_lvl  = 32'(init_l);
    end else begin
      e.t_a1    = (d < 0) ? SETTLE + 1 + ad : SETTLE + 1;
      e.t_a2    = (d > 0) ? SETTLE + 1 + ad : SETTLE + 1;
      e.end_lvl = 32'(dir);
      if (m != 2'd0) begin
        e.tmo      = 1;
        e.meas     = MAX_WAIT;
        e.done_cyc = SETTLE + 1 + MAX_WAIT + 1;
      end else if (dir) begin
        // Output rises on the first edge; two sync cycles later it is seen,
        // but the run cannot end before the lag edge has been issued.
        e.meas     = 2;
        e.done_cyc = SETTLE + 1 + ((ad + 1 > 3) ? ad + 1 : 3);
      end else begin
        e.meas     = ad + 2;
        e.done_cyc = SETTLE + 1 + ad + 3;
      end
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic run_meas(input int d, input logic dir, input logic [1:0] m, input bit stray);
    exp_t e;
    int   cyc;
    int   t1;
    int   t2;
    mode = m;
    exp_q.push_back(model(d, dir, m));
    delta    = DELTA_W'(d);
    dir_rise = dir;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    t1  = 0;
    t2  = 0;
    check("busy_after_start", 32'(busy), 1);
    check("init_lvl", 32'({myinA1, myinA2}), (~dir) ? 3 : 0);
    while (!done && cyc < LIMIT) begin
      if (t1 == 0 && myinA1 == dir) t1 = cyc;
      if (t2 == 0 && myinA2 == dir) t2 = cyc;
      if (stray && cyc == 3) begin
        start    = 1'b1;
        delta    = ~delta;
        dir_rise = ~dir_rise;
      end
      if (stray && cyc == 4) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    if (!done) begin
      check("done_wait", 0, 1);
      return;
    end
    if (t1 == 0 && myinA1 == dir) t1 = cyc;
    if (t2 == 0 && myinA2 == dir) t2 = cyc;
    check("meas", 32'(meas), e.meas);
    check("timeout", 32'(timeout), e.tmo);
    check("settle_err", 32'(settle_err), e.serr);
    check("done_cycle", cyc, e.done_cyc);
    check("edge_a1", t1, e.t_a1);
    check("edge_a2", t2, e.t_a2);
    check("busy_at_done", 32'(busy), 0);
    check("end_inputs", 32'({myinA1, myinA2}), e.end_lvl ? 3 : 0);
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("meas_held", 32'(meas), e.meas);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    delta    = '0;
    dir_rise = 1'b0;
    mode     = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_inputs", 32'({myinA1, myinA2}), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_flags", 32'({timeout, settle_err}), 0);
    check("rst_meas", 32'(meas), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_meas(0,    1'b1, 2'd0, 1'b0);
    run_meas(5,    1'b1, 2'd0, 1'b1);
    run_meas(5,    1'b0, 2'd0, 1'b0);
    run_meas(-128, 1'b0, 2'd0, 1'b0);
    run_meas(1,    1'b1, 2'd0, 1'b0);
    run_meas(-3,   1'b1, 2'd0, 1'b0);
    run_meas(0,    1'b1, 2'd1, 1'b0);
    run_meas(0,    1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_meas(int'($urandom_range(0, 60)) - 30, 1'($urandom_range(0, 1)), 2'd0, 1'b0);
    end

    // Reset in the middle of the gap, with an ignored start beforehand.
    mode     = 2'd0;
    delta    = DELTA_W'(50);
    dir_rise = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < SETTLE + 2; c++) begin
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      @(negedge clk);
    end
    check("gap_state", 32'(dbg_state), 32'(ST_GAP));
    check("gap_inputs", 32'({myinA1, myinA2}), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrst_inputs", 32'({myinA1, myinA2}), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_meas", 32'(meas), 0);
    @(negedge clk);
    run_meas(0, 1'b1, 2'd0, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
